// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcode/funct constants, controller state enum, datapath select encodings.
// Used by both the single-cycle decoder and the multi-cycle controller.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUBU    = 6'b100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDU    = 3'd5
  } state_t;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JAL    = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_OR     = 2'b10;

  localparam logic [1:0] A3_RD      = 2'b00;
  localparam logic [1:0] A3_RT      = 2'b01;
  localparam logic [1:0] A3_RA      = 2'b10;

  localparam logic [1:0] WD_ALU     = 2'b00;
  localparam logic [1:0] WD_DM      = 2'b01;
  localparam logic [1:0] WD_PC      = 2'b10;
  localparam logic [1:0] WD_HILO    = 2'b11;

  // One-hot instruction class; all-zero means "not decoded", executed as a nop.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic jr;
    logic lui;
    logic mult;
    logic div;
    logic mfhi;
    logic mflo;
  } instr_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction-class decoder producing one-hot flags from opcode/funct.
// MDU instructions are decoded only when MC_CTRL_MDU_EN is defined.
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output instr_t     instr
);

  logic special;

  always_comb begin
    instr   = '0;
    special = (opcode == OP_SPECIAL);

    instr.addu = special && (funct == FN_ADDU);
    instr.subu = special && (funct == FN_SUBU);
    instr.jr   = special && (funct == FN_JR);
    instr.ori  = (opcode == OP_ORI);
    instr.lw   = (opcode == OP_LW);
    instr.sw   = (opcode == OP_SW);
    instr.beq  = (opcode == OP_BEQ);
    instr.jal  = (opcode == OP_JAL);
    instr.lui  = (opcode == OP_LUI);
`ifdef MC_CTRL_MDU_EN
    instr.mult = special && (funct == FN_MULT);
    instr.div  = special && (funct == FN_DIV);
    instr.mfhi = special && (funct == FN_MFHI);
    instr.mflo = special && (funct == FN_MFLO);
`endif
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB(/MDU) sequencer with memory stalls.
// Optional multiply/divide sequencing is enabled by defining MC_CTRL_MDU_EN.
module mc_controller
  import mips_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = $clog2((MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Equ,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       PCWr,
  output logic       IRWr,
  output logic [1:0] NPCOp,
  output logic       GRFWr,
  output logic       DMWr,
  output logic       EXTOp,
  output logic       BSel,
  output logic [1:0] ALUOp,
  output logic [1:0] A3Sel,
  output logic [1:0] WDSel,
  output logic       MDStart,
  output logic       MDOp,
  output logic       HiLoWr,
  output logic       HiLoSel,
  output logic [2:0] state,
  output logic       retire
);

  state_t state_q, state_d;
  instr_t instr;
  logic   nop;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .instr  (instr)
  );

  assign nop   = (instr == '0);
  assign state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

`ifdef MC_CTRL_MDU_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // Memory handshake: imem_ready is looked at only in FETCH and dmem_ready only in MEM;
  // a high ready completes the access in that same cycle, a low ready holds the state.
  always_comb begin
    state_d = state_q;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    NPCOp   = NPC_PC4;
    GRFWr   = 1'b0;
    DMWr    = 1'b0;
    EXTOp   = 1'b0;
    BSel    = 1'b0;
    ALUOp   = ALU_ADD;
    A3Sel   = A3_RD;
    WDSel   = WD_ALU;
    MDStart = 1'b0;
    MDOp    = 1'b0;
    HiLoWr  = 1'b0;
    HiLoSel = 1'b0;
    retire  = 1'b0;
`ifdef MC_CTRL_MDU_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      S_FETCH: begin
        PCWr = imem_ready;
        IRWr = imem_ready;
        if (imem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        if (instr.jal) begin
          PCWr    = 1'b1;
          NPCOp   = NPC_JAL;
          GRFWr   = 1'b1;
          A3Sel   = A3_RA;
          WDSel   = WD_PC;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (instr.jr) begin
          PCWr    = 1'b1;
          NPCOp   = NPC_JR;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (instr.lw || instr.sw) begin
          ALUOp   = ALU_ADD;
          BSel    = 1'b1;
          EXTOp   = 1'b1;
          state_d = S_MEM;
        end else if (instr.beq) begin
          ALUOp   = ALU_SUB;
          NPCOp   = NPC_BRANCH;
          PCWr    = Equ;
          retire  = 1'b1;
          state_d = S_FETCH;
`ifdef MC_CTRL_MDU_EN
        end else if (instr.mult || instr.div) begin
          MDStart = 1'b1;
          MDOp    = instr.div;
          cnt_d   = instr.div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
          state_d = S_MDU;
`endif
        end else if (nop) begin
          // Undecoded words spend one EXEC cycle so a nop costs the same as a not-taken beq.
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          ALUOp   = instr.subu ? ALU_SUB : (instr.ori ? ALU_OR : ALU_ADD);
          BSel    = instr.ori || instr.lui;
          HiLoSel = instr.mfhi;
          state_d = S_WB;
        end
      end

      S_MEM: begin
        if (instr.sw) begin
          DMWr = 1'b1;
          if (dmem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (dmem_ready) begin
          state_d = S_WB;
        end
      end

      S_WB: begin
        GRFWr   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        A3Sel   = (instr.ori || instr.lui || instr.lw) ? A3_RT : A3_RD;
        if (instr.lw)                                 WDSel = WD_DM;
        else if (instr.lui || instr.mfhi || instr.mflo) WDSel = WD_HILO;
        HiLoSel = instr.mfhi;
      end

      S_MDU: begin
`ifdef MC_CTRL_MDU_EN
        if (cnt_q == '0) begin
          HiLoWr  = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        state_d = S_FETCH;
`endif
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule
